// File: rtl/circuit_bist.sv
// Self-test driver for the circuit datapath: LFSR stimulus out, MISR compaction of responses in.
// Optional CIRCUIT_BIST_ABORT_EN adds an abort input that cancels a run in progress.
module circuit_bist #(
  parameter int unsigned    W     = 96,
  parameter int unsigned    N_VEC = 100,
  parameter int unsigned    LAT   = 1,
  parameter logic [W-1:0]   SEED  = {{(W-1){1'b0}}, 1'b1},
  parameter logic [W-1:0]   POLY  = 96'h4000_8000_A000_0000_0000_0001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef CIRCUIT_BIST_ABORT_EN
  input  logic         abort,
`endif
  input  logic [W-1:0] golden,
  output logic         dut_en,
  output logic [W-1:0] dut_x,
  input  logic [W-1:0] dut_y,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [W-1:0] signature,
  output logic [15:0]  vec_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? {{(W-1){1'b0}}, 1'b1} : SEED;
  localparam logic [15:0]  N_VEC_C  = 16'(N_VEC);

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] v);
    return {v[W-2:0], 1'b0} ^ (v[W-1] ? POLY : '0);
  endfunction

  state_t         state, state_nx;
  logic [LAT-1:0] vpipe, vpipe_nx;
  logic           dut_en_nx, busy_nx, done_nx, pass_nx;
  logic [W-1:0]   dut_x_nx, sig_nx;
  logic [15:0]    vec_cnt_nx;

  // NOTE: every next-state value gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nx   = state;
    dut_en_nx  = dut_en;
    dut_x_nx   = dut_x;
    busy_nx    = busy;
    done_nx    = done;
    pass_nx    = pass;
    vec_cnt_nx = vec_cnt;
    vpipe_nx   = (vpipe << 1) | LAT'(dut_en);
    sig_nx     = vpipe[LAT-1] ? (lfsr_next(signature) ^ dut_y) : signature;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx   = RUN;
          dut_en_nx  = 1'b1;
          dut_x_nx   = SEED_EFF;
          vec_cnt_nx = 16'd1;
          busy_nx    = 1'b1;
          done_nx    = 1'b0;
          pass_nx    = 1'b0;
          sig_nx     = '0;
        end
      end
      RUN: begin
        if (vec_cnt < N_VEC_C) begin
          dut_x_nx   = lfsr_next(dut_x);
          vec_cnt_nx = vec_cnt + 16'd1;
        end else begin
          dut_en_nx = 1'b0;
          state_nx  = DRAIN;
        end
      end
      DRAIN: begin
        // Pipe empty means every response has been folded in; signature is final.
        if (vpipe == '0) begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          pass_nx  = (signature == golden);
        end
      end
      default: state_nx = IDLE;
    endcase

`ifdef CIRCUIT_BIST_ABORT_EN
    // Signature and vec_cnt are left as-is so the aborted run can be inspected.
    if (abort && (state == RUN || state == DRAIN)) begin
      state_nx   = IDLE;
      dut_en_nx  = 1'b0;
      busy_nx    = 1'b0;
      done_nx    = 1'b0;
      pass_nx    = 1'b0;
      vpipe_nx   = '0;
      sig_nx     = signature;
      vec_cnt_nx = vec_cnt;
      dut_x_nx   = dut_x;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dut_en    <= 1'b0;
      dut_x     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
      vec_cnt   <= '0;
      vpipe     <= '0;
    end else begin
      state     <= state_nx;
      dut_en    <= dut_en_nx;
      dut_x     <= dut_x_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      pass      <= pass_nx;
      signature <= sig_nx;
      vec_cnt   <= vec_cnt_nx;
      vpipe     <= vpipe_nx;
    end
  end

endmodule

// File: tb/tb_circuit_bist.sv
// Scoreboard bench for circuit_bist (W=8, POLY=1D, N_VEC=4, LAT=1) with a SEED=0 twin instance.
module tb_circuit_bist;

  localparam int unsigned W     = 8;
  localparam int unsigned N_VEC = 4;
  localparam int unsigned LAT   = 1;
  localparam logic [7:0]  POLY  = 8'h1D;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] golden = 8'h00;
  logic [7:0] dut_y = 8'h00;
  logic [7:0] y_mask = 8'h00;
`ifdef CIRCUIT_BIST_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic        dut_en, busy, done, pass;
  logic [7:0]  dut_x, signature;
  logic [15:0] vec_cnt;
  logic        en0, busy0, done0, pass0;
  logic [7:0]  x0, sig0;
  logic [15:0] cnt0;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_x_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  // Stand-in datapath with one cycle of latency.
  always @(posedge clk) dut_y <= dut_x ^ y_mask;

  circuit_bist #(.W(W), .N_VEC(N_VEC), .LAT(LAT), .SEED(8'h01), .POLY(POLY)) u_dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef CIRCUIT_BIST_ABORT_EN
    .abort(abort),
`endif
    .golden(golden), .dut_en(dut_en), .dut_x(dut_x), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .signature(signature), .vec_cnt(vec_cnt)
  );

  circuit_bist #(.W(W), .N_VEC(N_VEC), .LAT(LAT), .SEED(8'h00), .POLY(POLY)) u_dut0 (
    .clk(clk), .rst(rst), .start(start),
`ifdef CIRCUIT_BIST_ABORT_EN
    .abort(abort),
`endif
    .golden(golden), .dut_en(en0), .dut_x(x0), .dut_y(dut_y),
    .busy(busy0), .done(done0), .pass(pass0), .signature(sig0), .vec_cnt(cnt0)
  );

  function automatic logic [7:0] tb_lfsr(input logic [7:0] v);
    logic [7:0] s;
    s = {v[6:0], 1'b0};
    if (v[7]) s = s ^ POLY;
    return s;
  endfunction

  // Every stimulus word seen with dut_en=1 must be the next one the scoreboard expects.
  always @(negedge clk) begin
    if (dut_en) begin
      checks++;
      if (exp_x_q.size() == 0) begin
        failures++;
        $display("FAIL dut_x_unexpected got=%h expected=none", dut_x);
      end else begin
        mon_exp = exp_x_q.pop_front();
        if (dut_x !== mon_exp) begin
          failures++;
          $display("FAIL dut_x_seq got=%h expected=%h", dut_x, mon_exp);
        end
      end
    end
  end

  // Queue the stimulus sequence and return the signature a correct MISR must end with.
  task automatic push_run(input logic [7:0] mask, output logic [7:0] exp_sig, output logic [7:0] last_x);
    logic [7:0] x;
    x = 8'h01;
    exp_sig = 8'h00;
    last_x = 8'h00;
    for (int k = 0; k < N_VEC; k++) begin
      exp_x_q.push_back(x);
      exp_sig = tb_lfsr(exp_sig) ^ (x ^ mask);
      last_x = x;
      x = tb_lfsr(x);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12 rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({dut_en, busy, done, pass} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b expected=0000", {dut_en, busy, done, pass});
    end
    checks++;
    if ({dut_x, signature} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_x_sig got=%h expected=0000", {dut_x, signature});
    end
    checks++;
    if (vec_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_vec_cnt got=%0d expected=0", vec_cnt);
    end
  endtask

  task automatic test_run(input string tag, input logic [7:0] mask, input logic [7:0] gold_xor,
                          input bit mid_start, output logic [7:0] sig_out);
    logic [7:0] exp_sig, last_x;
    logic       exp_pass;
    int n, cyc;
    y_mask = mask;
    push_run(mask, exp_sig, last_x);
    golden = exp_sig ^ gold_xor;
    exp_pass = (gold_xor == 8'h00);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({en0, x0} !== {1'b1, 8'h01}) begin
      failures++;
      $display("FAIL %s seed0_first got=%b/%h expected=1/01", tag, en0, x0);
    end
    n = busy ? 1 : 0;
    cyc = 1;
    while (!done && cyc < 40) begin
      start = (mid_start && n == 2);
      @(negedge clk);
      cyc++;
      if (busy) n++;
    end
    start = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s done_timeout got=0 expected=1", tag);
    end
    checks++;
    if (n != 6) begin
      failures++;
      $display("FAIL %s busy_cycles got=%0d expected=6", tag, n);
    end
    checks++;
    if (signature !== exp_sig) begin
      failures++;
      $display("FAIL %s signature got=%h expected=%h", tag, signature, exp_sig);
    end
    checks++;
    if (pass !== exp_pass) begin
      failures++;
      $display("FAIL %s pass got=%b expected=%b", tag, pass, exp_pass);
    end
    checks++;
    if ({busy, dut_en, vec_cnt} !== {2'b00, 16'd4}) begin
      failures++;
      $display("FAIL %s end_state got=%b%b/%0d expected=00/4", tag, busy, dut_en, vec_cnt);
    end
    checks++;
    if (dut_x !== last_x) begin
      failures++;
      $display("FAIL %s dut_x_hold got=%h expected=%h", tag, dut_x, last_x);
    end
    checks++;
    if (exp_x_q.size() != 0) begin
      failures++;
      $display("FAIL %s vectors_missing got=%0d expected=0", tag, exp_x_q.size());
    end
    checks++;
    if ({done0, sig0} !== {1'b1, exp_sig}) begin
      failures++;
      $display("FAIL %s seed0_sig got=%b/%h expected=1/%h", tag, done0, sig0, exp_sig);
    end
    golden = golden ^ 8'hFF;
    repeat (2) @(negedge clk);
    checks++;
    if ({done, pass} !== {1'b1, exp_pass}) begin
      failures++;
      $display("FAIL %s pass_held got=%b%b expected=1%b", tag, done, pass, exp_pass);
    end
    sig_out = signature;
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp_sig, last_x;
    int cyc;
    y_mask = 8'h00;
    push_run(8'h00, exp_sig, last_x);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (vec_cnt != 16'd2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (vec_cnt !== 16'd2) begin
      failures++;
      $display("FAIL mid_reset_reach got=%0d expected=2", vec_cnt);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({dut_en, busy, done, pass, dut_x, signature, vec_cnt} !== 36'h0) begin
      failures++;
      $display("FAIL mid_reset_async got=%h expected=0", {dut_en, busy, done, pass, dut_x, signature, vec_cnt});
    end
    checks++;
    if ({en0, busy0, cnt0} !== 18'h0) begin
      failures++;
      $display("FAIL mid_reset_seed0 got=%h expected=0", {en0, busy0, cnt0});
    end
    @(negedge clk);
    rst = 1'b1;
    exp_x_q.delete();
  endtask

  task automatic test_reset_vs_start();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, dut_en} !== 2'b00) begin
      failures++;
      $display("FAIL reset_wins got=%b expected=00", {busy, dut_en});
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

`ifdef CIRCUIT_BIST_ABORT_EN
  task automatic test_abort();
    logic [7:0] exp_sig, last_x;
    int cyc;
    push_run(8'h00, exp_sig, last_x);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (vec_cnt != 16'd3 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if ({dut_en, busy, done, vec_cnt} !== {3'b000, 16'd3}) begin
      failures++;
      $display("FAIL abort_state got=%b%b%b/%0d expected=000/3", dut_en, busy, done, vec_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL abort_idle got=%b expected=00", {busy, done});
    end
    exp_x_q.delete();
  endtask
`endif

  initial begin
    logic [7:0] s_a, s_b, s_c;
    test_reset();
    test_run("delayed_x_pass", 8'h00, 8'h00, 1'b0, s_a);
    test_run("delayed_x_fail", 8'h00, 8'h21, 1'b0, s_a);
    test_run("masked_mid_start", 8'h5A, 8'h00, 1'b1, s_b);
    test_run("masked_rerun", 8'h5A, 8'h00, 1'b0, s_c);
    checks++;
    if (s_c !== s_b) begin
      failures++;
      $display("FAIL rerun_repeat got=%h expected=%h", s_c, s_b);
    end
    test_mid_reset();
    test_reset_vs_start();
`ifdef CIRCUIT_BIST_ABORT_EN
    test_abort();
`endif
    test_run("after_reset", 8'h3C, 8'h00, 1'b0, s_a);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
